quad_encoder_tx: RTL and testbench

Quadrature encoder transmitter. It converts step commands (direction, edge count, edge period) into a clean two-phase A/B quadrature waveform, which is the counterpart of the rotary-encoder decoders on the timer's `ui_in` encoder pins. Its intended uses are on-chip self-test loopback into the encoder inputs and driving an external quadrature consumer. Phase state persists between commands, so the emulated shaft position is continuous.

---
 rtl/quad_encoder_tx.sv | 207 ++++++++++++++++++++
 tb/tb_quad_encoder_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_tx.sv
// Quadrature encoder transmitter: turns (direction, edge count, edge period) commands into A/B.
// Define QUAD_ENCODER_TX_BOUNCE_EN to emit every edge as a toggle/restore/toggle contact bounce.
module quad_encoder_tx #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StZero
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       p_q, p_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             dir_q, dir_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] per_in;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             done_q, done_d;
    logic             emit;
    logic             emit_dir;
`ifdef QUAD_ENCODER_TX_BOUNCE_EN
    logic [1:0]       bnc_q, bnc_d;
    logic             abort_pend_q, abort_pend_d;
    logic             stop;
`endif

    // Phase index to {A,B}: 0=00, 1=10, 2=11, 3=01 (Gray sequence).
    function automatic logic [1:0] phase_ab(input logic [1:0] p);
        return {p[1] ^ p[0], p[1]};
    endfunction

`ifdef QUAD_ENCODER_TX_BOUNCE_EN
    // A bounced edge occupies three cycles, so edges can be no closer than that.
    assign per_in = (cmd_period < DIV_W'(3)) ? DIV_W'(3) : cmd_period;
`else
    assign per_in = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
`endif

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        a_d      = a_q;
        b_d      = b_q;
        dir_d    = dir_q;
        per_d    = per_q;
        div_d    = div_q;
        steps_d  = steps_q;
        done_d   = 1'b0;
        emit     = 1'b0;
        emit_dir = dir_q;
`ifdef QUAD_ENCODER_TX_BOUNCE_EN
        bnc_d        = bnc_q;
        abort_pend_d = abort_pend_q;
        stop         = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    per_d    = per_in;
                    emit_dir = cmd_dir;
                    if (cmd_steps == '0) begin
                        state_d = StZero;
                        steps_d = '0;
                    end else if (per_in == DIV_W'(1)) begin
                        // Period 1: the first edge must already be visible the cycle after accept.
                        emit    = 1'b1;
                        steps_d = cmd_steps - CNT_W'(1);
                        div_d   = per_in;
                        if (cmd_steps == CNT_W'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end else begin
                        steps_d = cmd_steps;
                        div_d   = per_in - DIV_W'(1);
                        state_d = StRun;
                    end
                end
            end

            StRun: begin
`ifdef QUAD_ENCODER_TX_BOUNCE_EN
                if (bnc_q != 2'd0) begin
                    // Bounce in flight: finish it even if aborted, then settle.
                    if (div_q > DIV_W'(1)) begin
                        div_d = div_q - DIV_W'(1);
                    end
                    stop = abort | abort_pend_q;
                    if (abort) begin
                        abort_pend_d = 1'b1;
                        steps_d      = '0;
                    end
                    if (bnc_q == 2'd2) begin
                        {a_d, b_d} = phase_ab(dir_q ? p_q - 2'd1 : p_q + 2'd1);
                        bnc_d      = 2'd1;
                    end else begin
                        {a_d, b_d} = phase_ab(p_q);
                        bnc_d      = 2'd0;
                        if (stop || steps_q == '0) begin
                            state_d      = StIdle;
                            done_d       = ~stop;
                            abort_pend_d = 1'b0;
                            steps_d      = '0;
                        end
                    end
                end else
`endif
                if (abort) begin
                    state_d = StIdle;
                    steps_d = '0;
                end else if (div_q <= DIV_W'(1)) begin
                    emit  = 1'b1;
                    div_d = per_q;
                    if (steps_q != '0) begin
                        steps_d = steps_q - CNT_W'(1);
                    end
`ifndef QUAD_ENCODER_TX_BOUNCE_EN
                    if (steps_q <= CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
`endif
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            StZero: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end

            default: state_d = StIdle;
        endcase

        if (emit) begin
            p_d        = emit_dir ? p_q + 2'd1 : p_q - 2'd1;
            {a_d, b_d} = phase_ab(p_d);
`ifdef QUAD_ENCODER_TX_BOUNCE_EN
            bnc_d      = 2'd2;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            dir_q   <= 1'b0;
            per_q   <= '0;
            div_q   <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
`ifdef QUAD_ENCODER_TX_BOUNCE_EN
            bnc_q        <= 2'd0;
            abort_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dir_q   <= dir_d;
            per_q   <= per_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            done_q  <= done_d;
`ifdef QUAD_ENCODER_TX_BOUNCE_EN
            bnc_q        <= bnc_d;
            abort_pend_q <= abort_pend_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == StIdle) && !rst;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign enc_a      = a_q;
    assign enc_b      = b_q;
    assign steps_left = steps_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Directed bench for quad_encoder_tx: expected edges/done are queued at accept and matched
// against the outputs as they change; ready/busy are checked every cycle against a small model.
module tb_quad_encoder_tx;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;
    logic             enc_a;
    logic             enc_b;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] steps_left;

    typedef struct {
        int         cyc;
        logic [1:0] ab;
        logic       dn;
    } ev_t;

    ev_t        sbq[$];
    int         n_cmp      = 0;
    int         n_err      = 0;
    int         cyc        = 0;
    int         model_t    = -10;
    int         model_free = 0;
    int         abort_cyc  = -1;
    int         abort_off  = 0;
    logic [1:0] p_m        = 2'd0;
    logic [1:0] prev_ab    = 2'b00;
    bit         accepted   = 1'b0;

    always #5 clk = ~clk;

    quad_encoder_tx #(
        .CNT_W(CNT_W),
        .DIV_W(DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .abort     (abort),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .busy      (busy),
        .done      (done),
        .steps_left(steps_left)
    );

    function automatic logic [1:0] ab_of(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called for the cycle in which a command is accepted (cycle T = cyc).
    task automatic push_cmd();
        int  peff;
        int  n;
        int  lim;
        int  ec;
        bit  aborted;
        ev_t e;
        peff      = (cmd_period == '0) ? 1 : int'(cmd_period);
        n         = int'(cmd_steps);
        model_t   = cyc;
        aborted   = (abort_off > 0) && (abort_off < n * peff);
        abort_cyc = (abort_off > 0) ? cyc + abort_off : -1;
        lim       = aborted ? cyc + abort_off : cyc + n * peff;
        abort_off = 0;
        if (n == 0) begin
            e.cyc = cyc + 2;
            e.ab  = ab_of(p_m);
            e.dn  = 1'b1;
            sbq.push_back(e);
            model_free = cyc + 2;
        end else begin
            for (int k = 1; k <= n; k++) begin
                ec = cyc + k * peff;
                if (ec <= lim) begin
                    p_m   = cmd_dir ? p_m + 2'd1 : p_m - 2'd1;
                    e.cyc = ec;
                    e.ab  = ab_of(p_m);
                    e.dn  = (k == n);
                    sbq.push_back(e);
                end
            end
            model_free = aborted ? lim + 1 : cyc + n * peff;
        end
    endtask

    task automatic tick();
        logic [1:0] cur;
        ev_t        e;
        if (!rst && cmd_valid && cyc >= model_free) begin
            push_cmd();
            accepted = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        cur = {enc_a, enc_b};
        if (!rst) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(cyc >= model_free));
            chk("busy", 32'(busy), 32'((cyc > model_t) && (cyc < model_free)));
        end
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            chk("edge_missing", 32'(cyc), 32'(e.cyc));
        end
        if (cur !== prev_ab || done !== 1'b0) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("edge_cycle", 32'(cyc), 32'(e.cyc));
                chk("enc_ab", 32'(cur), 32'(e.ab));
                chk("done", 32'(done), 32'(e.dn));
            end else begin
                chk("spurious_ab", 32'(cur), 32'(prev_ab));
                chk("spurious_done", 32'(done), 32'(0));
            end
        end
        prev_ab = cur;
        abort   = (cyc == abort_cyc);
    endtask

    task automatic issue(input logic d, input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] per);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = s;
        cmd_period = per;
        accepted   = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) tick();
        chk("accepted", 32'(accepted), 32'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 70000 && (sbq.size() > 0 || cyc < model_free); i++) tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 8'd4;
        cmd_period = 16'd3;
        abort      = 1'b0;

        // Reset held two cycles with a command offered: nothing may be accepted.
        tick();
        tick();
        chk("rst_enc_a", 32'(enc_a), 32'(0));
        chk("rst_enc_b", 32'(enc_b), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_ready", 32'(cmd_ready), 32'(0));
        chk("rst_steps_left", 32'(steps_left), 32'(0));
        rst       = 1'b0;
        cmd_valid = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'(1));

        // Forward, 4 edges, period 3.
        issue(1'b1, 8'd4, 16'd3);
        chk("fwd_steps_left_t1", 32'(steps_left), 32'(4));
        drain();
        chk("fwd_final_ab", 32'({enc_a, enc_b}), 32'(2'b00));

        // Reverse from p0 with period 0, back-to-back in the done cycle, then a zero-step command.
        issue(1'b0, 8'd2, 16'd0);
        drain();
        issue(1'b0, 8'd0, 16'd5);
        drain();
        chk("zero_steps_left", 32'(steps_left), 32'(0));

        // Forward with period 1 returns the phase to p0.
        issue(1'b1, 8'd2, 16'd1);
        drain();
        chk("p0_ab", 32'({enc_a, enc_b}), 32'(2'b00));

        // Abort at T+5 of a 5-edge, period-2 command.
        abort_off = 5;
        issue(1'b1, 8'd5, 16'd2);
        chk("abort_steps_left_t1", 32'(steps_left), 32'(5));
        tick();
        chk("abort_steps_left_t2", 32'(steps_left), 32'(4));
        drain();
        chk("abort_hold_ab", 32'({enc_a, enc_b}), 32'(2'b11));
        chk("abort_steps_left", 32'(steps_left), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        issue(1'b1, 8'd1, 16'd2);
        drain();
        chk("after_abort_ab", 32'({enc_a, enc_b}), 32'(2'b01));

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        tick();
        chk("idle_abort_ab", 32'({enc_a, enc_b}), 32'(2'b01));

        // Busy protection, then a second command held valid until the done cycle.
        issue(1'b0, 8'd3, 16'd4);
        for (int i = 0; i < 5; i++) begin
            cmd_valid  = (i % 2 == 0);
            cmd_dir    = 1'b1;
            cmd_steps  = 8'd7;
            cmd_period = 16'd1;
            tick();
        end
        cmd_valid = 1'b0;
        issue(1'b1, 8'd2, 16'd2);
        drain();

        // Full-length command at period 1: counter must stop at 0.
        issue(1'b0, 8'd255, 16'd1);
        drain();
        chk("long_steps_left", 32'(steps_left), 32'(0));

        // Largest legal period.
        issue(1'b1, 8'd1, 16'hFFFF);
        chk("maxper_steps_left_t1", 32'(steps_left), 32'(1));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
